sdram_frame_fetcher: RTL and testbench



---
 rtl/zf_video_pkg.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 65 ++++++
 rtl/sdram_frame_fetcher.sv | 153 +++++++++++++++
 tb/tb_sdram_frame_fetcher.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zf_video_pkg.sv
// Shared types and constants for the video fetch path.
//   fetch_state_t : frame fetcher FSM states
//   PIX_W         : pixel word width
//   BRIDGE_ADDR_W : byte address width of the Avalon bridge
//   DEFAULT_*     : default frame geometry, FIFO depth and acknowledge timeout
package zf_video_pkg;

  localparam int unsigned PIX_W         = 16;
  localparam int unsigned BRIDGE_ADDR_W = 26;

  localparam int unsigned FRAME_WIDTH            = 320;
  localparam int unsigned FRAME_HEIGHT           = 240;
  localparam int unsigned DEFAULT_FRAME_WORDS    = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned DEFAULT_FIFO_DEPTH     = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StDrain,
    StDone,
    StHalt
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO: head_data shows the oldest word whenever the FIFO is not empty.
//   clk, reset   : clock and synchronous active-high reset
//   flush        : empty the FIFO at the next edge (overrides push/pop)
//   push         : write push_data (ignored when full unless a pop frees a slot)
//   pop          : drop the head word (ignored when empty)
//   head_data    : head word, 0 when empty
//   empty, full  : occupancy flags
//   level        : current occupancy, 0..DEPTH
module sync_fifo_fwft
  import zf_video_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push;
  logic              do_pop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LevelW'(DEPTH));
  assign level     = level_q;
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally (DEPTH is a power of two); level_q tells full from empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (!do_push && do_pop) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_frame_fetcher.sv
// Streams one frame of pixel words out of SDRAM via the Avalon bridge into a show-ahead FIFO.
//   clk, reset                 : system clock, synchronous active-high reset
//   enable                     : allow new read requests
//   frame_start                : one-cycle pulse restarting the frame
//   avalon_bridge_*            : single-word read master (one request outstanding at most)
//   pix_rd_en/pix_data/pix_valid : consumer pop interface, head word shown ahead
//   fifo_level                 : FIFO occupancy
//   frame_done                 : all FRAME_WORDS fetched
//   underflow, timeout_err     : sticky error flags, cleared by a restart
module sdram_frame_fetcher
  import zf_video_pkg::*;
#(
  parameter logic [BRIDGE_ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned              FRAME_WORDS    = DEFAULT_FRAME_WORDS,
  parameter int unsigned              FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned              TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          frame_start,
  output logic [BRIDGE_ADDR_W-1:0]      avalon_bridge_address,
  output logic [1:0]                    avalon_bridge_byte_enable,
  output logic                          avalon_bridge_read,
  output logic                          avalon_bridge_write,
  output logic [PIX_W-1:0]              avalon_bridge_write_data,
  input  logic                          avalon_bridge_acknowledge,
  input  logic [PIX_W-1:0]              avalon_bridge_read_data,
  input  logic                          pix_rd_en,
  output logic [PIX_W-1:0]              pix_data,
  output logic                          pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          underflow,
  output logic                          timeout_err
);

  localparam int unsigned CntW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] FrameWordsC = CntW'(FRAME_WORDS);
  localparam logic [TmoW-1:0] TmoLast     = TmoW'(TIMEOUT_CYCLES - 1);

  fetch_state_t             state_q;
  logic [BRIDGE_ADDR_W-1:0] addr_q;
  logic                     read_q;
  logic                     frame_done_q;
  logic                     underflow_q;
  logic                     timeout_err_q;
  logic [CntW-1:0]          word_cnt_q;
  logic [CntW-1:0]          word_cnt_inc;
  logic [TmoW-1:0]          tmo_cnt_q;
  logic                     in_req;
  logic                     restart;
  logic                     push;
  logic                     fifo_empty;
  logic                     fifo_full;

  assign in_req       = (state_q == StReq) || (state_q == StDrain);
  // While a request is outstanding the restart waits for its acknowledge.
  assign restart      = in_req ? (avalon_bridge_acknowledge &&
                                  ((state_q == StDrain) || frame_start))
                               : frame_start;
  // Data acknowledged for a request overtaken by frame_start is dropped.
  assign push         = (state_q == StReq) && avalon_bridge_acknowledge && !frame_start;
  assign word_cnt_inc = word_cnt_q + 1'b1;

  sync_fifo_fwft #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (push),
    .push_data (avalon_bridge_read_data),
    .pop       (pix_rd_en),
    .head_data (pix_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= BASE_ADDR;
      read_q        <= 1'b0;
      word_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      underflow_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (pix_rd_en && fifo_empty) underflow_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          // A free slot at issue guarantees room at acknowledge (one request in flight).
          if (!frame_start && enable && (word_cnt_q < FrameWordsC) && !fifo_full) begin
            state_q   <= StReq;
            read_q    <= 1'b1;
            tmo_cnt_q <= '0;
          end
        end
        StReq, StDrain: begin
          if (avalon_bridge_acknowledge) begin
            read_q <= 1'b0;
            if (push) begin
              addr_q     <= addr_q + BRIDGE_ADDR_W'(2);
              word_cnt_q <= word_cnt_inc;
              if (word_cnt_inc == FrameWordsC) begin
                state_q      <= StDone;
                frame_done_q <= 1'b1;
              end else begin
                state_q <= StIdle;
              end
            end
          end else if (tmo_cnt_q == TmoLast) begin
            read_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= StHalt;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (frame_start) state_q <= StDrain;
          end
        end
        StDone, StHalt: begin
        end
        default: state_q <= StIdle;
      endcase

      if (restart) begin
        state_q       <= StIdle;
        addr_q        <= BASE_ADDR;
        word_cnt_q    <= '0;
        frame_done_q  <= 1'b0;
        underflow_q   <= 1'b0;
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign avalon_bridge_address     = addr_q;
  assign avalon_bridge_byte_enable = 2'b11;
  assign avalon_bridge_read        = read_q;
  assign avalon_bridge_write       = 1'b0;
  assign avalon_bridge_write_data  = '0;
  assign pix_valid                 = !fifo_empty;
  assign frame_done                = frame_done_q;
  assign underflow                 = underflow_q;
  assign timeout_err               = timeout_err_q;

endmodule

// File: tb/tb_sdram_frame_fetcher.sv
// Self-checking bench for sdram_frame_fetcher: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_sdram_frame_fetcher;

  localparam logic [25:0] BASE  = 26'h100;
  localparam int unsigned FW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        frame_start;
  logic [25:0] address;
  logic [1:0]  byte_enable;
  logic        read;
  logic        write;
  logic [15:0] write_data;
  logic        ack;
  logic [15:0] rdata;
  logic        pix_rd_en;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [2:0]  fifo_level;
  logic        frame_done;
  logic        underflow;
  logic        timeout_err;

  always #5 clk = ~clk;

  sdram_frame_fetcher #(
    .BASE_ADDR      (BASE),
    .FRAME_WORDS    (FW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .enable                    (enable),
    .frame_start               (frame_start),
    .avalon_bridge_address     (address),
    .avalon_bridge_byte_enable (byte_enable),
    .avalon_bridge_read        (read),
    .avalon_bridge_write       (write),
    .avalon_bridge_write_data  (write_data),
    .avalon_bridge_acknowledge (ack),
    .avalon_bridge_read_data   (rdata),
    .pix_rd_en                 (pix_rd_en),
    .pix_data                  (pix_data),
    .pix_valid                 (pix_valid),
    .fifo_level                (fifo_level),
    .frame_done                (frame_done),
    .underflow                 (underflow),
    .timeout_err               (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected FIFO contents, next word index and flags.
  logic [15:0] q[$];
  int          exp_idx;
  bit          discard;
  bit          halted;
  bit          uf_m;
  bit          to_m;
  bit          exp_read;
  int          run;

  // Bridge model and scenario knobs.
  int          lat;
  int          wait_cnt;
  bit          dead;
  bit          rand_lat;
  bit          pop_with_ack;
  bit          force_en;
  logic [15:0] force_data;
  int          reads_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("read", 32'(read), 32'(exp_read));
    check_eq("address", 32'(address), 32'(BASE + 26'(2 * exp_idx)));
    check_eq("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
    check_eq("fifo_level", 32'(fifo_level), 32'(q.size()));
    check_eq("pix_data", 32'(pix_data), 32'(q.size() != 0 ? q[0] : 16'h0));
    check_eq("frame_done", 32'(frame_done), 32'(exp_idx == FW));
    check_eq("underflow", 32'(underflow), 32'(uf_m));
    check_eq("timeout_err", 32'(timeout_err), 32'(to_m));
    check_eq("const_outputs", 32'({byte_enable, write, write_data}), 32'({2'b11, 1'b0, 16'h0}));
  endtask

  // One clock: sample inputs, advance the model by the spec rules, check, drive the bridge.
  task automatic tick();
    logic        rd, ak, fs, pe, en;
    logic [15:0] dat;
    int          qpre;
    bit          restart, push;
    rd = read; ak = ack; fs = frame_start; pe = pix_rd_en; en = enable; dat = rdata;
    qpre = q.size();
    @(posedge clk);
    restart = 1'b0;
    push    = 1'b0;
    if (rd && ak) begin
      exp_read = 1'b0;
      if (discard || fs) restart = 1'b1;
      else push = 1'b1;
      discard = 1'b0;
      run     = 0;
    end else if (rd) begin
      run++;
      if (run >= TMO) begin
        exp_read = 1'b0;
        halted   = 1'b1;
        to_m     = 1'b1;
        discard  = 1'b0;
        run      = 0;
      end else begin
        exp_read = 1'b1;
        if (fs) discard = 1'b1;
      end
    end else begin
      exp_read = en && !fs && !halted && (exp_idx < FW) && (qpre < DEPTH);
      if (fs) restart = 1'b1;
    end
    if (pe) begin
      if (qpre > 0) void'(q.pop_front());
      else uf_m = 1'b1;
    end
    if (push) begin
      q.push_back(dat);
      exp_idx++;
    end
    if (fs) q.delete();
    if (restart) begin
      exp_idx = 0;
      uf_m    = 1'b0;
      to_m    = 1'b0;
      halted  = 1'b0;
    end
    #1;
    check_outputs();
    if (!rd && read) reads_seen++;
    if (ak) begin
      ack      = 1'b0;
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 4);
    end else if (read && !dead) begin
      wait_cnt++;
      if (wait_cnt > lat) begin
        ack      = 1'b1;
        rdata    = force_en ? force_data : 16'($urandom);
        force_en = 1'b0;
      end
    end else if (!read) begin
      wait_cnt = 0;
    end
    frame_start = 1'b0;
    if (pop_with_ack) pix_rd_en = ack;
  endtask

  task automatic wait_read(input logic lvl, input string tag);
    int n = 0;
    while (read !== lvl && n < 400) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(read), 32'(lvl));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_rd_en = 1'b0;
    ack = 1'b0; rdata = '0;
    exp_idx = 0; discard = 0; halted = 0; uf_m = 0; to_m = 0; exp_read = 0; run = 0;
    lat = 1; wait_cnt = 0; dead = 0; rand_lat = 0; pop_with_ack = 0; force_en = 0;
    force_data = '0; reads_seen = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_outputs();

    // Pop on empty FIFO: sticky underflow, level stays 0, cleared by frame_start.
    pix_rd_en = 1'b1;
    tick();
    pix_rd_en = 1'b0;
    tick();
    check_eq("underflow_sticky", 32'(underflow), 32'd1);
    check_eq("underflow_level", 32'(fifo_level), 32'd0);
    frame_start = 1'b1;
    tick();
    check_eq("underflow_cleared", 32'(underflow), 32'd0);

    // Idle consumer: exactly DEPTH reads, then one pop buys exactly one more.
    enable = 1'b1;
    lat = 1;
    reads_seen = 0;
    repeat (40) tick();
    check_eq("fill_reads", 32'(reads_seen), 32'(DEPTH));
    check_eq("fill_level", 32'(fifo_level), 32'(DEPTH));
    pix_rd_en = 1'b1;
    tick();
    pix_rd_en = 1'b0;
    repeat (20) tick();
    check_eq("refill_reads", 32'(reads_seen), 32'(DEPTH + 1));

    // Consume the rest: frame_done after the last word and no extra read.
    pix_rd_en = 1'b1;
    for (int n = 0; n < 400 && !frame_done; n++) tick();
    check_eq("frame_done_seen", 32'(frame_done), 32'd1);
    repeat (20) tick();
    check_eq("frame_reads", 32'(reads_seen), 32'(FW));
    check_eq("frame_done_addr", 32'(address), 32'(BASE + 26'(2 * FW)));
    pix_rd_en = 1'b0;

    // Push and pop in the same cycle with level 2 keeps level 2.
    frame_start = 1'b1;
    tick();
    for (int n = 0; n < 100 && fifo_level != 3'd2; n++) tick();
    check_eq("level_two", 32'(fifo_level), 32'd2);
    pop_with_ack = 1'b1;
    reads_seen = 0;
    repeat (30) tick();
    pop_with_ack = 1'b0;
    pix_rd_en = 1'b0;
    check_eq("pushpop_level", 32'(fifo_level), 32'd2);
    check_eq("pushpop_active", 32'(reads_seen > 5), 32'd1);

    // Slow acknowledge: request held, 0xBEEF visible the cycle after its push.
    enable = 1'b0;
    wait_read(1'b0, "quiesce");
    frame_start = 1'b1;
    tick();
    lat = 10;
    force_en = 1'b1;
    force_data = 16'hBEEF;
    enable = 1'b1;
    for (int n = 0; n < 100 && !pix_valid; n++) tick();
    check_eq("beef_valid", 32'(pix_valid), 32'd1);
    check_eq("beef_data", 32'(pix_data), 32'h0000BEEF);

    // frame_start in the 3rd cycle of a pending request.
    wait_read(1'b1, "req_rise");
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    check_eq("restart_flush", 32'(fifo_level), 32'd0);
    check_eq("restart_read_held", 32'(read), 32'd1);
    wait_read(1'b0, "drain_ack");
    check_eq("drain_discarded", 32'(pix_valid), 32'd0);
    wait_read(1'b1, "restart_req");
    check_eq("restart_addr", 32'(address), 32'(BASE));

    // Acknowledge never comes: timeout, halt, then frame_start recovers.
    dead = 1'b1;
    reads_seen = 0;
    repeat (300) tick();
    check_eq("timeout_err_set", 32'(timeout_err), 32'd1);
    check_eq("timeout_read_low", 32'(read), 32'd0);
    check_eq("timeout_no_reads", 32'(reads_seen), 32'd0);
    dead = 1'b0;
    lat = 1;
    frame_start = 1'b1;
    tick();
    check_eq("timeout_cleared", 32'(timeout_err), 32'd0);
    wait_read(1'b1, "resume_req");
    check_eq("resume_addr", 32'(address), 32'(BASE));

    // Randomized traffic.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      pix_rd_en   = ($urandom_range(0, 1) == 0);
      frame_start = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
